decryption_128: RTL

Iterative AES-128 inverse cipher (FIPS-197 InvCipher) that recovers 128-bit plaintext from ciphertext and the 128-bit cipher key. It pairs with `encryption_128` at the receive end of the same data path.
- Internally expands the key forward, storing all eleven round keys, then runs the ten inverse rounds at one round per clock.
- Inverse and forward S-boxes are computed in-block: GF(2^8) inversion plus affine or inverse-affine transform.

---
 rtl/decryption_128.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/decryption_128.sv
// rtl/decryption_128.sv - iterative AES-128 inverse cipher, one round per clock
// Key is expanded forward into eleven stored round keys, then ten inverse rounds run.
module decryption_128 #(
  parameter int N = 128,
  parameter int R = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [N-1:0]         cipher_text,
  input  logic [N-1:0]         key,
  output logic [N-1:0]         plain_text,
  output logic                 done,
  output logic                 busy,
  output logic [$clog2(R)-1:0] round
);

  localparam int RW = $clog2(R);

  typedef enum logic [1:0] {IDLE, KEYEXP, ROUND} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic [127:0] ct_q, st_q;
  logic [127:0] rk [0:10];

  logic [3:0]   rk_idx;
  logic [127:0] rk_sel, key_next, ark, round_out;

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 == x^-1 in GF(2^8); maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] p, r;
    p = x;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] b;
    b = gf_inv(x);
    return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte r+4c holds state row r, column c; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c-r+4)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv_sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
      o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
      o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
      o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
    end
    return o;
  endfunction

  // Key expansion reads the previous key; inverse rounds read the key indexed by cnt
  assign rk_idx = (state_q == KEYEXP) ? cnt_q - 4'd1 : cnt_q;

  always_comb begin
    rk_sel = '0;
    for (int i = 0; i < 11; i++)
      if (rk_idx == 4'(i)) rk_sel = rk[i];
  end

  assign key_next  = expand(rk_sel, rcon(cnt_q));
  assign ark       = inv_sub_bytes(inv_shift_rows(st_q)) ^ rk_sel;
  assign round_out = (cnt_q == 4'd0) ? ark : inv_mix_columns(ark);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = KEYEXP;
      KEYEXP:  if (cnt_q == 4'd10) state_d = ROUND;
      ROUND:   if (cnt_q == 4'd0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      ct_q       <= '0;
      st_q       <= '0;
      plain_text <= '0;
      done       <= 1'b0;
      for (int i = 0; i < 11; i++) rk[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            ct_q  <= cipher_text;
            rk[0] <= key;
            cnt_q <= 4'd1;
          end
        end
        KEYEXP: begin
          for (int i = 1; i < 11; i++)
            if (cnt_q == 4'(i)) rk[i] <= key_next;
          if (cnt_q == 4'd10) begin
            st_q  <= ct_q ^ key_next;
            cnt_q <= 4'd9;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ROUND: begin
          if (cnt_q == 4'd0) begin
            plain_text <= round_out;
            done       <= 1'b1;
          end else begin
            st_q  <= round_out;
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: cnt_q <= '0;
      endcase
    end
  end

  assign busy  = (state_q != IDLE);
  assign round = (state_q == ROUND) ? RW'(R - int'(cnt_q)) : '0;

endmodule
